// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants and FSM encoding for the register-bank dump reader.
// Module parameters default to these values.
package regfile_dump_reader_pkg;

    localparam int DEF_ADDR_W         = 5;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_NUM_REGS       = 32;
    localparam int DEF_BYTES_PER_WORD = DEF_DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_dump_reader_word_byte_serializer.sv
// Snapshots one DATA_W word and presents it MSB-first as a byte stream
// with a valid/ready handshake. Bytes are stable while stalled.
module word_byte_serializer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_ready,
    output logic [7:0]        o_data,
    output logic              o_valid,
    output logic              o_last_byte,
    output logic              o_word_done
);

    localparam int BPW   = DATA_W / 8;
    localparam int CNT_W = $clog2(BPW + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_count;
    logic              r_valid;
    logic              w_fire;

    assign w_fire      = r_valid & i_ready;
    assign o_data      = r_shift[DATA_W-1 -: 8];
    assign o_valid     = r_valid;
    assign o_last_byte = r_valid && (r_count == LAST_CNT);
    assign o_word_done = w_fire && (r_count == LAST_CNT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    // NOTE: the snapshot register is a plain flop bank (not a memory), so it is
    // reset along with the rest of the state to give a defined out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_count <= '0;
            r_valid <= 1'b1;
        end else if (w_fire) begin
            r_shift <= r_shift << 8;
            r_count <= r_count + 1'b1;
            if (r_count == LAST_CNT) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks the register bank through one combinational
// read port and streams every word MSB-first over a byte valid/ready link.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    // One spare index bit lets NUM_REGS == 2**ADDR_W reach its end value
    // without wrapping back to zero.
    localparam int IDX_W = ADDR_W + 1;
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_REGS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

    state_e            r_state;
    state_e            w_next_state;
    logic [IDX_W-1:0]  r_index;
    logic [IDX_W-1:0]  w_index_inc;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              w_load;
    logic              w_word_done;
    logic              w_last_byte;
    logic              w_ser_valid;
    logic [7:0]        w_ser_data;

    assign w_index_inc = r_index + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                // Index past the last register: the walk is finished.
                if (r_index == IDX_END) begin
                    w_next_state = S_DONE;
                end else begin
                    w_load       = 1'b1;
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                if (w_word_done) begin
                    w_next_state = S_FETCH;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index   <= '0;
            r_rd_addr <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_index   <= '0;
            r_rd_addr <= '0;
        end else if (r_state == S_SEND && w_word_done) begin
            r_index <= w_index_inc;
            // Keep the last real address once the walk has run off the end.
            if (w_index_inc != IDX_END) begin
                r_rd_addr <= w_index_inc[ADDR_W-1:0];
            end
        end
    end

    word_byte_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_word      (rd_data),
        .i_ready     (out_ready),
        .o_data      (w_ser_data),
        .o_valid     (w_ser_valid),
        .o_last_byte (w_last_byte),
        .o_word_done (w_word_done)
    );

    assign busy      = (r_state == S_FETCH) || (r_state == S_SEND);
    assign done      = (r_state == S_DONE);
    assign rd_addr   = r_rd_addr;
    assign out_data  = w_ser_data;
    assign out_valid = w_ser_valid;
    assign out_last  = (r_state == S_SEND) && w_last_byte && (r_index == IDX_LAST);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: scenario table, a byte-stream
// reference built from bank contents, and hand-written reset/abort sequences.
module tb_regfile_dump_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_drv;
    logic        rdy_drv;
    bit          sel;
    logic [31:0] bank [0:31];

    // 32-register instance
    logic        start32, busy32, done32, valid32, last32;
    logic [4:0]  rd_addr32;
    logic [31:0] rd_data32;
    logic [7:0]  data32;
    // 4-register instance
    logic        start4, busy4, done4, valid4, last4;
    logic [4:0]  rd_addr4;
    logic [31:0] rd_data4;
    logic [7:0]  data4;

    assign start32   = start_drv & ~sel;
    assign start4    = start_drv & sel;
    assign rd_data32 = bank[rd_addr32];
    assign rd_data4  = bank[rd_addr4];

    regfile_dump_reader dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .busy(busy32), .done(done32),
        .rd_addr(rd_addr32), .rd_data(rd_data32), .out_data(data32),
        .out_valid(valid32), .out_ready(rdy_drv), .out_last(last32)
    );

    regfile_dump_reader #(.NUM_REGS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
        .rd_addr(rd_addr4), .rd_data(rd_data4), .out_data(data4),
        .out_valid(valid4), .out_ready(rdy_drv), .out_last(last4)
    );

    logic       o_busy, o_done, o_valid, o_last;
    logic [7:0] o_data;
    assign o_busy  = sel ? busy4  : busy32;
    assign o_done  = sel ? done4  : done32;
    assign o_valid = sel ? valid4 : valid32;
    assign o_last  = sel ? last4  : last32;
    assign o_data  = sel ? data4  : data32;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // fill: 0 = i*0x01010101, 1 = random, 2 = keep current contents
    typedef struct {
        string       name;
        bit          sel;
        int          nregs;
        int          mode;
        int          fill;
        int          ov_idx;
        logic [31:0] ov_val;
        int          abort_after;
        int          wr_idx;
        logic [31:0] wr_val;
        bit          extra_starts;
        int          exp_first;
        int          exp_done;
    } vec_t;

    localparam int NROWS     = 9;
    localparam int CYC_LIMIT = 2000;
    vec_t rows [NROWS];

    function automatic bit ready_pat(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4 == 0) || (c % 4 == 3);
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    task automatic do_abort();
        rst_n     = 1'b0;
        start_drv = 1'b0;
        #1;
        check("abort_busy",  o_busy,  1'b0);
        check("abort_valid", o_valid, 1'b0);
        check("abort_done",  o_done,  1'b0);
        check("abort_last",  o_last,  1'b0);
        check("abort_data",  o_data,  8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", o_done, 1'b0);
            check("abort_hold_busy", o_busy, 1'b0);
        end
        rst_n = 1'b1;
    endtask

    task automatic run_dump(input vec_t v);
        logic [7:0] exp_q [$];
        int n_bytes, got, cyc, dones, first_valid, last_acc, done_cyc, word_end;
        logic       stall;
        logic [7:0] stall_data;
        logic       hs;
        n_bytes     = v.nregs * 4;
        got         = 0;
        dones       = 0;
        first_valid = -1;
        last_acc    = -1;
        done_cyc    = -1;
        word_end    = -10;
        stall       = 1'b0;
        stall_data  = 8'h00;
        for (int i = 0; i < v.nregs; i++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(bank[i][31-8*b -: 8]);

        @(posedge clk); #1;
        start_drv = 1'b1;
        rdy_drv   = ready_pat(v.mode, 0);
        for (cyc = 0; cyc < CYC_LIMIT; cyc++) begin
            @(negedge clk);
            hs = o_valid && rdy_drv;
            if (dones == 0 && !o_done)
                check({v.name, ":busy"}, o_busy, cyc >= 1);
            else
                check({v.name, ":busy_end"}, o_busy, 1'b0);
            if (got >= n_bytes)
                check({v.name, ":extra_valid"}, o_valid, 1'b0);
            if (cyc == word_end + 1)
                check({v.name, ":word_gap"}, o_valid, 1'b0);
            if (stall) begin
                check({v.name, ":stall_valid"}, o_valid, 1'b1);
                check({v.name, ":stall_data"}, o_data, stall_data);
            end
            if (o_valid && first_valid < 0)
                first_valid = cyc;
            if (o_valid && got < n_bytes)
                check({v.name, ":last_flag"}, o_last, got == n_bytes - 1);
            else
                check({v.name, ":last_idle"}, o_last, 1'b0);
            if (hs && got < n_bytes) begin
                check({v.name, ":byte"}, o_data, exp_q[got]);
                got++;
                last_acc = cyc;
                if (got % 4 == 0) word_end = cyc;
                if (v.wr_idx >= 0 && got == v.wr_idx * 4 + 1)
                    bank[v.wr_idx] = v.wr_val;
                if (v.abort_after > 0 && got == v.abort_after) begin
                    do_abort();
                    return;
                end
            end
            stall      = o_valid && !rdy_drv;
            stall_data = o_data;
            if (o_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
                // a start presented in the DONE cycle must be ignored
                if (v.extra_starts) start_drv = 1'b1;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 3) break;
            @(posedge clk); #1;
            start_drv = v.extra_starts && (cyc + 1 == 3 || cyc + 1 == 40);
            rdy_drv   = ready_pat(v.mode, cyc + 1);
        end
        start_drv = 1'b0;
        check({v.name, ":done_seen"}, done_cyc >= 0, 1'b1);
        check({v.name, ":byte_count"}, got, n_bytes);
        check({v.name, ":done_pulses"}, dones, 1);
        check({v.name, ":first_valid"}, first_valid, v.exp_first);
        check({v.name, ":done_after_last"}, done_cyc, last_acc + 2);
        if (v.exp_done > 0)
            check({v.name, ":done_cycle"}, done_cyc, v.exp_done);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0] = '{"seq_pattern",   1'b0, 32, 0, 0, -1, 32'h0,        0,  -1, 32'h0,        1'b0, 2, 162};
        rows[1] = '{"ready_1001",    1'b0, 32, 1, 0,  5, 32'hDEADBEEF, 0,  -1, 32'h0,        1'b0, 2, -1};
        rows[2] = '{"snapshot",      1'b0, 32, 0, 1,  3, 32'h12345678, 0,   3, 32'hFFFFFFFF, 1'b0, 2, 162};
        rows[3] = '{"snapshot_next", 1'b0, 32, 0, 2, -1, 32'h0,        0,  -1, 32'h0,        1'b0, 2, 162};
        rows[4] = '{"extra_starts",  1'b0, 32, 0, 1, -1, 32'h0,        0,  -1, 32'h0,        1'b1, 2, 162};
        rows[5] = '{"random_ready",  1'b0, 32, 2, 1, -1, 32'h0,        0,  -1, 32'h0,        1'b1, 2, -1};
        rows[6] = '{"abort",         1'b0, 32, 0, 0, -1, 32'h0,        50, -1, 32'h0,        1'b0, 2, -1};
        rows[7] = '{"after_abort",   1'b0, 32, 0, 2, -1, 32'h0,        0,  -1, 32'h0,        1'b0, 2, 162};
        rows[8] = '{"regs4",         1'b1, 4,  0, 1, -1, 32'h0,        0,  -1, 32'h0,        1'b0, 2, 22};

        rst_n     = 1'b0;
        start_drv = 1'b0;
        rdy_drv   = 1'b0;
        sel       = 1'b0;
        for (int i = 0; i < 32; i++) bank[i] = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_busy32",  busy32,  1'b0);
        check("rst_done32",  done32,  1'b0);
        check("rst_valid32", valid32, 1'b0);
        check("rst_last32",  last32,  1'b0);
        check("rst_data32",  data32,  8'h00);
        check("rst_addr32",  rd_addr32, 5'd0);
        check("rst_busy4",   busy4,   1'b0);
        check("rst_valid4",  valid4,  1'b0);
        rst_n = 1'b1;

        // out_ready high while idle must not produce anything
        rdy_drv = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready_valid", valid32, 1'b0);
        check("idle_ready_busy",  busy32,  1'b0);

        for (int r = 0; r < NROWS; r++) begin
            sel = rows[r].sel;
            if (rows[r].fill == 0) begin
                for (int i = 0; i < 32; i++) bank[i] = 32'h0101_0101 * i;
            end else if (rows[r].fill == 1) begin
                for (int i = 0; i < 32; i++) bank[i] = $urandom;
            end
            if (rows[r].ov_idx >= 0) bank[rows[r].ov_idx] = rows[r].ov_val;
            run_dump(rows[r]);
            repeat (2) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
